// File: rtl/text_console_pkg.sv
// Shared geometry, FSM states and control codes for the text-mode VRAM writer.
package text_console_pkg;

  localparam int COLS          = 80;
  localparam int ROWS          = 30;
  localparam int WORDS_PER_ROW = COLS / 4;
  localparam int VRAM_WORDS    = ROWS * WORDS_PER_ROW;

  typedef enum logic [2:0] {
    IDLE,
    PUT,
    CLEAR,
    SCR_RD,
    SCR_WR,
    SCR_FILL
  } state_t;

  localparam logic [7:0] CH_BS = 8'h08;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_FF = 8'h0C;
  localparam logic [7:0] CH_CR = 8'h0D;

  // Word address of the cell holding (row, col); four cells share one word.
  function automatic logic [9:0] cell_addr(input logic [4:0] row, input logic [6:0] col,
                                           input int wpr = WORDS_PER_ROW);
    return 10'(row) * 10'(wpr) + 10'(col[6:2]);
  endfunction

endpackage

// File: rtl/text_console_writer.sv
// Byte-stream to glyph-write engine for the text-mode VRAM (BRAM port A).
// Tracks an 80x30 cursor, handles CR/LF/BS/FF and runs hardware clear and
// scroll-up sequences while holding off new characters.
module text_console_writer #(
  parameter int         COLS           = 80,
  parameter int         ROWS           = 30,
  parameter logic [7:0] FILL_CHAR      = 8'h20,
  parameter bit         CLEAR_ON_RESET = 1'b1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        char_valid,
  input  logic [7:0]  char_data,
  input  logic        char_inv,
  output logic        char_ready,
  output logic        busy,
  output logic [6:0]  cursor_col,
  output logic [4:0]  cursor_row,
  output logic        bram_en_a,
  output logic [3:0]  bram_we_a,
  output logic [9:0]  bram_addr_a,
  output logic [31:0] bram_din_a,
  input  logic [31:0] bram_dout_a
);
  import text_console_pkg::*;

  localparam int         WPR         = COLS / 4;
  localparam int         NWORDS      = ROWS * WPR;
  localparam logic [9:0] WPR10       = 10'(WPR);
  localparam logic [9:0] LAST_WORD   = 10'(NWORDS - 1);
  localparam logic [9:0] SCROLL_LAST = 10'(NWORDS - WPR - 1);
  localparam logic [6:0] LAST_COL    = 7'(COLS - 1);
  localparam logic [4:0] LAST_ROW    = 5'(ROWS - 1);

  state_t      state;
  logic [6:0]  col;
  logic [4:0]  row;
  logic [9:0]  k;      // word counter shared by clear, copy and fill passes
  logic [7:0]  glyph;  // latched {inv, code[6:0]} for the PUT cycle

  // Cursor, word counter and state sequencing.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= CLEAR_ON_RESET ? CLEAR : IDLE;
      col   <= '0;
      row   <= '0;
      k     <= '0;
      glyph <= '0;
    end else begin
      case (state)
        IDLE: if (char_valid) begin
          if (char_data >= 8'h20 && char_data <= 8'h7E) begin
            glyph <= {char_inv, char_data[6:0]};
            state <= PUT;
          end else begin
            case (char_data)
              CH_CR: col <= '0;
              CH_BS: if (col != '0) col <= col - 7'd1;
              CH_LF: begin
                col <= '0;
                if (row < LAST_ROW) row <= row + 5'd1;
                else begin
                  k     <= '0;
                  state <= SCR_RD;
                end
              end
              CH_FF: begin
                col   <= '0;
                row   <= '0;
                k     <= '0;
                state <= CLEAR;
              end
              default: ;
            endcase
          end
        end
        PUT: begin
          if (col < LAST_COL) begin
            col   <= col + 7'd1;
            state <= IDLE;
          end else begin
            col <= '0;
            if (row < LAST_ROW) begin
              row   <= row + 5'd1;
              state <= IDLE;
            end else begin
              k     <= '0;
              state <= SCR_RD;
            end
          end
        end
        CLEAR, SCR_FILL: begin
          if (k == LAST_WORD) state <= IDLE;
          else                k     <= k + 10'd1;
        end
        SCR_RD: state <= SCR_WR;
        SCR_WR: begin
          k     <= k + 10'd1;
          state <= (k == SCROLL_LAST) ? SCR_FILL : SCR_RD;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Port A and status decode; the copy write forwards read data straight
  // from the BRAM so each copied word costs one read and one write cycle.
  always_comb begin
    char_ready  = 1'b0;
    busy        = 1'b0;
    cursor_col  = '0;
    cursor_row  = '0;
    bram_en_a   = 1'b0;
    bram_we_a   = '0;
    bram_addr_a = '0;
    bram_din_a  = '0;
    if (!Reset) begin
      char_ready = (state == IDLE);
      busy       = (state inside {CLEAR, SCR_RD, SCR_WR, SCR_FILL});
      cursor_col = col;
      cursor_row = row;
      case (state)
        PUT: begin
          bram_en_a   = 1'b1;
          bram_we_a   = 4'b0001 << col[1:0];
          bram_addr_a = cell_addr(row, col, WPR);
          bram_din_a  = {4{glyph}};
        end
        CLEAR, SCR_FILL: begin
          bram_en_a   = 1'b1;
          bram_we_a   = 4'hF;
          bram_addr_a = k;
          bram_din_a  = {4{FILL_CHAR}};
        end
        SCR_RD: begin
          bram_en_a   = 1'b1;
          bram_addr_a = k + WPR10;
        end
        SCR_WR: begin
          bram_en_a   = 1'b1;
          bram_we_a   = 4'hF;
          bram_addr_a = k;
          bram_din_a  = bram_dout_a;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_text_console_writer.sv
// Directed + randomized bench for text_console_writer with a VRAM model and
// a screen-level reference (cursor + 600-word image).
module tb_text_console_writer;
  localparam logic [31:0] FILLW = 32'h20202020;

  logic        Clk = 1'b0, Reset = 1'b1, char_valid = 1'b0, char_inv = 1'b0;
  logic [7:0]  char_data = '0;
  logic        char_ready, busy, bram_en_a;
  logic [6:0]  cursor_col;
  logic [4:0]  cursor_row;
  logic [3:0]  bram_we_a;
  logic [9:0]  bram_addr_a;
  logic [31:0] bram_din_a, bram_dout_a;

  always #5 Clk = ~Clk;

  text_console_writer #(.COLS(80), .ROWS(30), .FILL_CHAR(8'h20), .CLEAR_ON_RESET(1'b1)) dut (
    .Clk(Clk), .Reset(Reset), .char_valid(char_valid), .char_data(char_data),
    .char_inv(char_inv), .char_ready(char_ready), .busy(busy),
    .cursor_col(cursor_col), .cursor_row(cursor_row), .bram_en_a(bram_en_a),
    .bram_we_a(bram_we_a), .bram_addr_a(bram_addr_a), .bram_din_a(bram_din_a),
    .bram_dout_a(bram_dout_a)
  );

  // VRAM port A: byte-enabled write, read-first, one-cycle read latency.
  logic [31:0] mem [1024];
  always @(posedge Clk) begin
    if (bram_en_a) begin
      for (int b = 0; b < 4; b++)
        if (bram_we_a[b]) mem[bram_addr_a][b*8 +: 8] <= bram_din_a[b*8 +: 8];
      bram_dout_a <= mem[bram_addr_a];
    end
  end

  // Port-A activity log, sampled mid-cycle.
  typedef struct { logic [9:0] a; logic [3:0] we; logic [31:0] d; } wr_t;
  wr_t        wq[$];
  logic [9:0] rq[$];
  int         busy_cnt = 0, rdy_bad = 0;
  always @(negedge Clk) begin
    if (bram_en_a) begin
      if (bram_we_a != 4'h0) wq.push_back('{bram_addr_a, bram_we_a, bram_din_a});
      else                   rq.push_back(bram_addr_a);
    end
    if (busy) busy_cnt++;
    if (busy && char_ready) rdy_bad++;
  end

  // Screen reference.
  logic [31:0] exp_vram [600];
  logic [31:0] pre [600];
  int exp_col = 0, exp_row = 0;
  int ncomp = 0, nfail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    ncomp++;
    assert (obs === exp_v) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic ref_clear();
    for (int i = 0; i < 600; i++) exp_vram[i] = FILLW;
    exp_col = 0;
    exp_row = 0;
  endtask

  task automatic ref_scroll();
    for (int i = 0; i < 580; i++) exp_vram[i] = exp_vram[i+20];
    for (int i = 580; i < 600; i++) exp_vram[i] = FILLW;
  endtask

  task automatic ref_char(input logic [7:0] c, input logic inv);
    if (c >= 8'h20 && c <= 8'h7E) begin
      exp_vram[exp_row*20 + exp_col/4][(exp_col%4)*8 +: 8] = {inv, c[6:0]};
      if (exp_col < 79) exp_col++;
      else begin
        exp_col = 0;
        if (exp_row < 29) exp_row++;
        else ref_scroll();
      end
    end else if (c == 8'h0D) exp_col = 0;
    else if (c == 8'h08) begin
      if (exp_col > 0) exp_col--;
    end else if (c == 8'h0A) begin
      exp_col = 0;
      if (exp_row < 29) exp_row++;
      else ref_scroll();
    end else if (c == 8'h0C) ref_clear();
  endtask

  task automatic wait_ready(input int lim);
    int n = 0;
    @(negedge Clk);
    while (char_ready !== 1'b1 && n < lim) begin
      @(negedge Clk);
      n++;
    end
    if (char_ready !== 1'b1) chk("ready_timeout", {63'd0, char_ready}, 64'd1);
  endtask

  task automatic send(input logic [7:0] c, input logic inv);
    wait_ready(2000);
    char_valid = 1'b1;
    char_data  = c;
    char_inv   = inv;
    @(posedge Clk);
    #1 char_valid = 1'b0;
    ref_char(c, inv);
  endtask

  task automatic chk_cursor(input string tag);
    chk(tag, {52'd0, cursor_row, cursor_col}, {52'd0, 5'(exp_row), 7'(exp_col)});
  endtask

  task automatic chk_vram(input string tag);
    int bad = 0;
    for (int i = 0; i < 600; i++) if (mem[i] !== exp_vram[i]) bad++;
    chk(tag, 64'(bad), 64'd0);
  endtask

  // Count of deviations from a full 0..599 fill sequence starting at wq[start].
  function automatic int clear_errs(input int start);
    int bad = 0;
    if (wq.size() < start + 600) return 600;
    for (int i = 0; i < 600; i++)
      if (wq[start+i].a !== 10'(i) || wq[start+i].we !== 4'hF || wq[start+i].d !== FILLW) bad++;
    return bad;
  endfunction

  task automatic goto_cell(input int c, input int r);
    send(8'h0C, 1'b0);
    for (int i = 0; i < r; i++) send(8'h0A, 1'b0);
    for (int i = 0; i < c; i++) send(8'(32'h21 + $urandom_range(0, 90)), 1'($urandom_range(0, 1)));
    wait_ready(2000);
  endtask

  initial begin
    int n0, bad, n;
    logic [7:0] c;
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    for (int i = 0; i < 600; i++) exp_vram[i] = '0;

    // Reset: outputs quiet, then a full clear.
    @(posedge Clk); #1;
    @(negedge Clk);
    chk("rst_outs", {3'd0, char_ready, busy, cursor_col, cursor_row, bram_en_a, bram_we_a,
                     bram_addr_a, bram_din_a}, 64'd0);
    @(posedge Clk); #1 Reset = 1'b0;
    wq.delete(); rq.delete(); busy_cnt = 0;
    ref_clear();
    wait_ready(2000);
    chk("clr_cnt", 64'(wq.size()), 64'd600);
    chk("clr_seq", 64'(clear_errs(0)), 64'd0);
    chk("clr_busy", 64'(busy_cnt), 64'd600);
    chk_cursor("clr_cursor");
    chk_vram("clr_vram");

    // Two glyphs in one word.
    wq.delete();
    send(8'h41, 1'b0);
    send(8'h42, 1'b1);
    wait_ready(2000);
    chk("put_cnt", 64'(wq.size()), 64'd2);
    if (wq.size() >= 2) begin
      chk("put0", {22'd0, wq[0].a, wq[0].we, wq[0].d}, {22'd0, 10'd0, 4'b0001, 32'h41414141});
      chk("put1", {22'd0, wq[1].a, wq[1].we, wq[1].d}, {22'd0, 10'd0, 4'b0010, 32'hC2C2C2C2});
    end
    chk_cursor("put_cursor");
    chk_vram("put_vram");

    // Control codes at (5,3).
    goto_cell(5, 3);
    chk_cursor("at_5_3");
    n0 = wq.size();
    send(8'h0A, 1'b0); wait_ready(10); chk_cursor("lf");
    send(8'h08, 1'b0); wait_ready(10); chk_cursor("bs_col0");
    send(8'h07, 1'b0); wait_ready(10); chk_cursor("bel");
    send(8'h0D, 1'b0); wait_ready(10); chk_cursor("cr");
    chk("ctl_nowrite", 64'(wq.size()), 64'(n0));
    send(8'h58, 1'b0); send(8'h59, 1'b1); send(8'h08, 1'b0);
    wait_ready(10); chk_cursor("bs_back");

    // Form feed from (10,12).
    goto_cell(10, 12);
    wq.delete(); rq.delete(); busy_cnt = 0;
    send(8'h0C, 1'b0);
    wait_ready(2000);
    chk("ff_cnt", 64'(wq.size()), 64'd600);
    chk("ff_seq", 64'(clear_errs(0)), 64'd0);
    chk("ff_reads", 64'(rq.size()), 64'd0);
    chk_cursor("ff_cursor");
    chk_vram("ff_vram");

    // Random byte stream against the screen reference.
    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 15))
        10: c = 8'h0A;
        11: c = 8'h0D;
        12: c = 8'h08;
        13: c = 8'($urandom_range(0, 31));
        14: c = 8'($urandom_range(127, 255));
        default: c = 8'($urandom_range(32, 126));
      endcase
      send(c, 1'($urandom_range(0, 1)));
      wait_ready(2000);
      chk_cursor("rnd_cursor");
    end
    chk_vram("rnd_vram");

    // Last cell triggers a scroll.
    goto_cell(79, 29);
    for (int i = 0; i < 600; i++) pre[i] = exp_vram[i];
    pre[599][31:24] = 8'h5A;
    wq.delete(); rq.delete(); busy_cnt = 0;
    send(8'h5A, 1'b0);
    wait_ready(2000);
    chk("scr_wcnt", 64'(wq.size()), 64'd601);
    chk("scr_rcnt", 64'(rq.size()), 64'd580);
    if (wq.size() == 601 && rq.size() == 580) begin
      chk("scr_put", {22'd0, wq[0].a, wq[0].we, wq[0].d}, {22'd0, 10'd599, 4'b1000, 32'h5A5A5A5A});
      bad = 0;
      for (int i = 0; i < 580; i++)
        if (rq[i] !== 10'(i + 20) || wq[1+i].a !== 10'(i) || wq[1+i].we !== 4'hF ||
            wq[1+i].d !== pre[i+20]) bad++;
      for (int i = 580; i < 600; i++)
        if (wq[1+i].a !== 10'(i) || wq[1+i].we !== 4'hF || wq[1+i].d !== FILLW) bad++;
      chk("scr_seq", 64'(bad), 64'd0);
    end
    chk("scr_busy", 64'(busy_cnt), 64'd1180);
    chk_cursor("scr_cursor");
    chk_vram("scr_vram");

    // Reset in the middle of a scroll copy.
    send(8'h0A, 1'b0);
    n = 0;
    @(negedge Clk);
    while (!(busy === 1'b1 && bram_we_a === 4'hF && bram_addr_a === 10'd100) && n < 2000) begin
      @(negedge Clk);
      n++;
    end
    chk("abort_reach", 64'(n < 2000), 64'd1);
    Reset = 1'b1;
    @(negedge Clk);
    chk("abort_outs", {3'd0, char_ready, busy, cursor_col, cursor_row, bram_en_a, bram_we_a,
                       bram_addr_a, bram_din_a}, 64'd0);
    @(posedge Clk); #1 Reset = 1'b0;
    wq.delete(); rq.delete(); busy_cnt = 0;
    ref_clear();
    wait_ready(2000);
    chk("rclr_seq", 64'(clear_errs(0)), 64'd0);
    chk("rclr_busy", 64'(busy_cnt), 64'd600);
    chk_cursor("rclr_cursor");
    chk_vram("rclr_vram");
    chk("ready_in_busy", 64'(rdy_bad), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end

endmodule

// File: doc/text_console_writer.md
Name: text_console_writer

Overview:
- Writer end of the text-mode VRAM: turns a byte stream of character codes into glyph writes on BRAM port A.
- The HDMI text renderer reads the same VRAM on port B.
- Maintains an 80x30 cursor, interprets a small set of control codes, and performs hardware clear-screen and scroll-up.
- VRAM layout: word index = row*20 + col/4; byte lane = col[1:0], lane 0 = bits [7:0]; glyph byte = {inv, code[6:0]}.

Parameters:
- COLS, 80, characters per row; must be a multiple of 4.
- ROWS, 30, character rows.
- FILL_CHAR, 8'h20, glyph byte used by clear and scroll fill.
- CLEAR_ON_RESET, 1, when 1 a full clear runs after reset deasserts.

Ports:
- Clk  in  1  system clock, all logic on rising edge
- Reset  in  1  synchronous, active-high
- char_valid  in  1  char_data/char_inv valid
- char_data  in  8  character or control code
- char_inv  in  1  inversion attribute, written to glyph bit 7
- char_ready  out  1  block accepts a character this cycle
- busy  out  1  clear or scroll in progress
- cursor_col  out  7  current column, 0..COLS-1
- cursor_row  out  5  current row, 0..ROWS-1
- bram_en_a  out  1  port A enable
- bram_we_a  out  4  port A byte write enables
- bram_addr_a  out  10  port A word address, 0..599
- bram_din_a  out  32  port A write data
- bram_dout_a  in  32  port A read data, valid one cycle after a read (en=1, we=0)

Behaviour:
- Reset and outputs
  - Reset is synchronous and active-high on Clk.
  - While Reset is high, all outputs are 0 and the cursor is (0,0).
  - Next state is CLEAR if CLEAR_ON_RESET is 1, otherwise IDLE.
  - Reset asserted mid-operation aborts the operation immediately: bram_we_a=0 from the next cycle.
- States: IDLE, PUT, CLEAR, SCR_RD, SCR_WR, SCR_FILL.
- Handshake
  - char_ready = (state==IDLE).
  - A transfer occurs on a cycle with char_valid && char_ready. The block samples char_data and char_inv on that cycle.
  - busy = state in {CLEAR, SCR_RD, SCR_WR, SCR_FILL}.
- IDLE decode of an accepted code c:
  - 0x20..0x7E: go to PUT.
  - 0x0D (CR): col=0.
  - 0x08 (BS): col = col-1 if col>0, else unchanged; no erase.
  - 0x0A (LF): col=0. If row<ROWS-1, row+1; else go to SCR_RD with row unchanged.
  - 0x0C (FF): go to CLEAR; cursor=(0,0).
  - Any other code is consumed and ignored, with no BRAM access.
- PUT (exactly one cycle)
  - bram_en_a=1, bram_addr_a = row*20 + col[6:2].
  - bram_we_a = one-hot 1<<col[1:0].
  - bram_din_a = glyph byte replicated into all 4 lanes.
  - Cursor advances on the same edge.
  - If col<COLS-1: col+1, then IDLE.
  - Else if row<ROWS-1: col=0, row+1, then IDLE.
  - Else: col=0, row stays ROWS-1, then SCR_RD.
- Latency and throughput
  - Printable char accepted in cycle T is written in T+1; char_ready returns in T+2.
  - Control codes that need no scroll or clear update the cursor at the end of cycle T; char_ready stays 1.
- CLEAR
  - Word counter k = 0..599, one write per cycle: addr=k, we=4'hF, din={4{FILL_CHAR}}.
  - Takes 600 cycles, then IDLE.
- Scroll (cursor fixed at col 0, row ROWS-1 throughout)
  - For k = 0..579: SCR_RD reads addr k+20, then SCR_WR writes addr k with bram_dout_a, we=4'hF.
  - SCR_FILL then writes {4{FILL_CHAR}} to addr 580..599, one per cycle.
  - Total 1180 cycles, then IDLE.
- Arithmetic
  - Address computed as 10-bit unsigned; it never exceeds 599.
  - Counters are 10-bit and never wrap past 599.
  - bram_en_a=0 in IDLE.

Decomposition:
- Package text_console_pkg holds:
  - COLS, ROWS, WORDS_PER_ROW (=COLS/4), VRAM_WORDS (=600)
  - state enum
  - control-code constants CH_BS, CH_LF, CH_FF, CH_CR
  - function cell_addr(row, col)
- Single flat module; no sub-module is warranted.

Test Plan:
1. Reset 1 cycle with CLEAR_ON_RESET=1 -> 600 writes, addr 0..599, din 0x20202020, we 4'hF; busy high exactly 600 cycles; then char_ready=1 and cursor (0,0).
2. Send 0x41 inv=0, then 0x42 inv=1 -> addr 0, we 0001, din[7:0]=0x41; then addr 0, we 0010, din[15:8]=0xC2; cursor ends at (2,0).
3. Cursor at (5,3): send 0x0A -> (0,4); 0x08 -> (0,4), no write; 0x07 -> ignored, no write; 0x0D -> (0,4).
4. Cursor at (79,29): send 'Z' -> addr 599, we 1000, din[31:24]=0x5A.
   - Then 580 read/write pairs with word k = prior word k+20; words 580..599 = 0x20202020.
   - Cursor (0,29); busy for 1180 cycles; char_ready low until done.
5. Cursor at (10,12): send 0x0C -> 600 fill writes; cursor (0,0); no other addresses touched.
6. Assert Reset during scroll at copy word 100 -> next cycle we=0 and all outputs 0; after deassert a full CLEAR runs from addr 0.
